// File: rtl/key_debouncer.sv
// Push-button conditioner: synchronizes and debounces an active-low key, emits
// press/release/long-press strobes and steps a 2-bit blink-rate select on short presses.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 50,
  parameter int LONG_PRESS_CYCLES = 500
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_N,
  output logic       KEY_LEVEL,
  output logic       PRESS_PULSE,
  output logic       RELEASE_PULSE,
  output logic       LONG_PULSE,
  output logic [1:0] RATE_SEL
);

  // state       | meaning
  // IDLE        | key released and stable
  // DEB_PRESS   | counting consecutive pressed samples
  // PRESSED     | press accepted, hold counter running
  // LONG_HELD   | long press reported, hold counter saturated
  // DEB_RELEASE | counting consecutive released samples, origin remembered
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PRESSED     = 3'd2,
    LONG_HELD   = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  // A sample completes its run when the count of earlier samples already equals N-1.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [1:0]        key_sync;
  logic              pressed;
  state_t            state, state_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              origin_long, origin_long_nxt;
  logic              key_level_d, press_d, release_d, long_d;
  logic [1:0]        rate_sel_d;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) key_sync <= 2'b11;
    else       key_sync <= {key_sync[0], KEY_N};
  end

  assign pressed = ~key_sync[1];

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      origin_long <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
      origin_long <= origin_long_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    deb_cnt_nxt     = deb_cnt;
    hold_cnt_nxt    = hold_cnt;
    origin_long_nxt = origin_long;
    unique case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt   = DEB_PRESS;
          deb_cnt_nxt = DEB_W'(1);
        end else begin
          deb_cnt_nxt = '0;
        end
      end
      DEB_PRESS: begin
        if (!pressed) begin
          state_nxt   = IDLE;
          deb_cnt_nxt = '0;
        end else if (deb_cnt >= DEB_LAST) begin
          state_nxt    = PRESSED;
          deb_cnt_nxt  = '0;
          hold_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_nxt       = DEB_RELEASE;
          deb_cnt_nxt     = DEB_W'(1);
          origin_long_nxt = 1'b0;
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          if (hold_cnt >= HOLD_LAST) state_nxt = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (!pressed) begin
          state_nxt       = DEB_RELEASE;
          deb_cnt_nxt     = DEB_W'(1);
          origin_long_nxt = 1'b1;
        end
      end
      DEB_RELEASE: begin
        // hold_cnt is frozen here so a bounce resumes the long-press timing
        if (pressed) begin
          state_nxt   = origin_long ? LONG_HELD : PRESSED;
          deb_cnt_nxt = '0;
        end else if (deb_cnt >= DEB_LAST) begin
          state_nxt   = IDLE;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        deb_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    press_d     = (state == DEB_PRESS)   && (state_nxt == PRESSED);
    release_d   = (state == DEB_RELEASE) && (state_nxt == IDLE);
    long_d      = (state == PRESSED)     && (state_nxt == LONG_HELD);
    key_level_d = (state_nxt == PRESSED) || (state_nxt == LONG_HELD) ||
                  (state_nxt == DEB_RELEASE);
    rate_sel_d  = RATE_SEL;
    if (long_d)                         rate_sel_d = 2'd0;
    else if (release_d && !origin_long) rate_sel_d = RATE_SEL + 2'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      KEY_LEVEL     <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      LONG_PULSE    <= 1'b0;
      RATE_SEL      <= 2'd0;
    end else begin
      KEY_LEVEL     <= key_level_d;
      PRESS_PULSE   <= press_d;
      RELEASE_PULSE <= release_d;
      LONG_PULSE    <= long_d;
      RATE_SEL      <= rate_sel_d;
    end
  end

endmodule
